fetch_queue: RTL and testbench

Instruction buffer between `inst_fetch` and the decode stage. It decouples fetch from decode so that decode stalls and fetch bubbles caused by `mem_controller` arbitration do not stall each other. It stores up to DEPTH fetched instruction/PC pairs in order and presents the oldest entry to decode through a valid/ready handshake. A flush drops every buffered entry when the program counter is redirected.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/fetch_queue_mem.sv | 34 +++
 rtl/fetch_queue.sv | 94 +++++++++
 tb/tb_fetch_queue.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions used by inst_fetch, fetch_queue and decode.
package cpu_pkg;

  localparam int XLEN_DEF = 64;
  localparam int ILEN     = 32;

  // addi x0, x0, 0: presented to decode whenever no real instruction is available
  localparam logic [ILEN-1:0] INST_NOP = 32'h00000013;

  typedef struct packed {
    logic [ILEN-1:0]     inst;
    logic [XLEN_DEF-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for fetch_queue: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset; validity is tracked by the owner.
module fetch_queue_mem
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = XLEN_DEF,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [ILEN-1:0] winst,
  input  logic [XLEN-1:0] wpc,
  input  logic [AW-1:0]   raddr,
  output logic [ILEN-1:0] rinst,
  output logic [XLEN-1:0] rpc
);

  logic [ILEN-1:0] inst_q [DEPTH];
  logic [XLEN-1:0] pc_q   [DEPTH];

  // Write the incoming instruction/PC pair into its slot
  always_ff @(posedge clk) begin
    if (we) begin
      inst_q[waddr] <= winst;
      pc_q[waddr]   <= wpc;
    end
  end

  assign rinst = inst_q[raddr];
  assign rpc   = pc_q[raddr];

endmodule

// File: rtl/fetch_queue.sv
// In-order instruction buffer between inst_fetch and decode. Handshake outputs are
// decoded from registered state only, so neither side sees a combinational path
// from the other. A flush (PC redirect) empties the queue at the next edge.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = XLEN_DEF,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [ILEN-1:0] in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ILEN-1:0] out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic [CW-1:0]   count
);

  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic            push, pop;
  logic [ILEN-1:0] head_inst;
  logic [XLEN-1:0] head_pc;

  // No pass-through when full: in_ready must not depend on out_ready
  assign in_ready  = (count_q != CNT_FULL);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_q;

  // Stale storage is masked so it never reaches decode
  assign out_inst  = out_valid ? head_inst : INST_NOP;
  assign out_pc    = out_valid ? head_pc   : '0;

  // Next-state for pointers and occupancy; flush drops any same-cycle push/pop
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state; reset takes priority and matches the post-flush state
  always_ff @(posedge CLK) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .XLEN  (XLEN)
  ) u_mem (
    .clk   (CLK),
    .we    (push && !flush && !reset),
    .waddr (wr_ptr_q),
    .winst (in_inst),
    .wpc   (in_pc),
    .raddr (rd_ptr_q),
    .rinst (head_inst),
    .rpc   (head_pc)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH=4, XLEN=64).
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 64;
  localparam logic [31:0] NOP = 32'h00000013;

  logic            CLK = 1'b0;
  logic            reset, flush, in_valid, out_ready;
  logic            in_ready, out_valid;
  logic [31:0]     in_inst, out_inst;
  logic [XLEN-1:0] in_pc, out_pc;
  logic [2:0]      count;

  int total  = 0;
  int passes = 0;
  int fails  = 0;

  fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_inst   (in_inst),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_pc    (out_pc),
    .count     (count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // advance one edge; inputs change and outputs are sampled 1 time unit after it
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push1(input logic [31:0] inst, input logic [63:0] pc);
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_pc = '0;

    // reset state, during reset and the cycle after
    tick(); tick();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_inst", 64'(out_inst), 64'(NOP));
    chk("rst_out_pc", out_pc, 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_count", 64'(count), 64'd0);
    chk("post_rst_inst", 64'(out_inst), 64'(NOP));

    // single entry
    push1(32'h00500093, 64'h80000000);
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_inst", 64'(out_inst), 64'h00500093);
    chk("single_pc", out_pc, 64'h80000000);
    chk("single_count", 64'(count), 64'd1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("single_pop_count", 64'(count), 64'd0);
    chk("single_pop_valid", 64'(out_valid), 64'd0);

    // fill to full, refused fifth push, drain in order
    for (int i = 0; i < 4; i++) push1(32'h1000 + 32'(i), 64'(4 * i));
    chk("full_count", 64'(count), 64'd4);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    push1(32'h1004, 64'h10);
    chk("full_fifth_count", 64'(count), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", out_pc, 64'(4 * i));
      chk("drain_inst", 64'(out_inst), 64'(32'h1000 + 32'(i)));
      out_ready = 1'b1; tick(); out_ready = 1'b0;
    end
    chk("drained_valid", 64'(out_valid), 64'd0);
    chk("drained_inst", 64'(out_inst), 64'(NOP));
    chk("drained_pc", out_pc, 64'd0);

    // streaming through pointer wrap
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_inst = 32'h2000 + 32'(k);
      in_pc   = 64'h1000 + 64'(4 * k);
      if (k > 0) begin
        chk("stream_count", 64'(count), 64'd1);
        chk("stream_pc", out_pc, 64'h1000 + 64'(4 * (k - 1)));
      end
      tick();
    end
    in_valid = 1'b0;
    chk("stream_last_count", 64'(count), 64'd1);
    chk("stream_last_pc", out_pc, 64'h1024);
    tick(); out_ready = 1'b0;
    chk("stream_empty", 64'(count), 64'd0);

    // flush with simultaneous push and pop
    push1(32'h3000, 64'h20);
    push1(32'h3001, 64'h24);
    push1(32'h3002, 64'h28);
    chk("pre_flush_count", 64'(count), 64'd3);
    flush = 1'b1; in_valid = 1'b1; in_inst = 32'h3100; in_pc = 64'h100; out_ready = 1'b1;
    chk("flush_cycle_valid", 64'(out_valid), 64'd1);
    chk("flush_cycle_ready", 64'(in_ready), 64'd1);
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    push1(32'h3200, 64'h200);
    chk("post_flush_head", out_pc, 64'h200);
    chk("post_flush_count", 64'(count), 64'd1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("post_flush_empty", 64'(count), 64'd0);

    // reset has priority over flush mid-stream
    push1(32'h4000, 64'h300);
    push1(32'h4001, 64'h304);
    chk("pre_rst_count", 64'(count), 64'd2);
    reset = 1'b1; flush = 1'b1; in_valid = 1'b1; in_pc = 64'h308; out_ready = 1'b1;
    tick();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_out_pc", out_pc, 64'd0);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);

    // full with pop: pop happens, push refused
    for (int i = 0; i < 4; i++) push1(32'h5000 + 32'(i), 64'h400 + 64'(4 * i));
    out_ready = 1'b1; in_valid = 1'b1; in_inst = 32'h5004; in_pc = 64'h410;
    chk("fullpop_in_ready", 64'(in_ready), 64'd0);
    chk("fullpop_head", out_pc, 64'h400);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("fullpop_count", 64'(count), 64'd3);
    chk("fullpop_ready_after", 64'(in_ready), 64'd1);
    for (int i = 1; i < 4; i++) begin
      chk("fullpop_drain_pc", out_pc, 64'h400 + 64'(4 * i));
      out_ready = 1'b1; tick(); out_ready = 1'b0;
    end
    chk("fullpop_refused_gone", 64'(out_valid), 64'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
